// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and level/stage helpers for shifter_pipe
package shifter_pkg;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   function automatic int shw_of(input int width);
      return $clog2(width);
   endfunction

   // Spreads the log2(WIDTH) shift levels as evenly as possible over the stages
   function automatic int stage_of_level(input int k, input int stages, input int shw);
      return (k * stages) / shw;
   endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// rtl/shifter_pipe_if.sv - valid/ready operand and result bus of shifter_pipe
interface shifter_pipe_if
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAGW  = 5,
   parameter int SHW   = shw_of(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [SHW-1:0]   in_shamt;
   logic [2:0]       in_op;
   logic [TAGW-1:0]  in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_o;
   logic [TAGW-1:0]  out_tag;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_o, out_tag, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_o, out_tag, out_zero
   );
endinterface

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one pipeline slot: its assigned shift levels plus register and advance logic
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int TAGW   = 5,
   parameter int STAGES = 2,
   parameter int IDX    = 0,
   parameter int SHW    = shw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic [SHW-1:0]   i_shamt,
   input  logic [2:0]       i_op,
   input  logic [TAGW-1:0]  i_tag,
   input  logic             i_take,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [SHW-1:0]   o_shamt,
   output logic [2:0]       o_op,
   output logic [TAGW-1:0]  o_tag,
   output logic             o_zero
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SHW-1:0]   r_shamt;
   logic [2:0]       r_op;
   logic [TAGW-1:0]  r_tag;
   logic             r_zero;

   logic [WIDTH-1:0] w_lvl [0:SHW];
   logic             w_load;

   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                input logic [2:0] op, input int amt);
      case (op)
         OP_SLL:  f_shift = d << amt;
         OP_SRL:  f_shift = d >> amt;
         OP_SRA:  f_shift = $signed(d) >>> amt;
         OP_ROL:  f_shift = (d << amt) | (d >> (WIDTH - amt));
         OP_ROR:  f_shift = (d >> amt) | (d << (WIDTH - amt));
         default: f_shift = d;
      endcase
   endfunction

   assign w_lvl[0] = i_data;

   // Levels owned by another stage pass through untouched
   for (genvar k = 0; k < SHW; k++) begin : g_lvl
      localparam int AMT = 1 << k;
      if (stage_of_level(k, STAGES, SHW) == IDX) begin : g_act
         assign w_lvl[k+1] = i_shamt[k] ? f_shift(w_lvl[k], i_op, AMT) : w_lvl[k];
      end else begin : g_pass
         assign w_lvl[k+1] = w_lvl[k];
      end
   end

   assign o_ready = !r_valid || i_take;
   assign w_load  = o_ready && i_valid && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
         r_op    <= '0;
         r_tag   <= '0;
         r_zero  <= 1'b0;
      end else begin
         if (flush)
            r_valid <= 1'b0;
         else if (o_ready)
            r_valid <= i_valid;
         if (w_load) begin
            r_data  <= w_lvl[SHW];
            r_shamt <= i_shamt;
            r_op    <= i_op;
            r_tag   <= i_tag;
            r_zero  <= (w_lvl[SHW] == '0);
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;
   assign o_op    = r_op;
   assign o_tag   = r_tag;
   assign o_zero  = r_zero;
endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter with valid/ready, tag sideband and flush
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   shifter_pipe_if.slave   bus
);
   localparam int SHW = shw_of(WIDTH);

   // Index s is the input of stage s; index STAGES is the final output
   logic             w_valid [0:STAGES];
   logic [WIDTH-1:0] w_data  [0:STAGES];
   logic [SHW-1:0]   w_shamt [0:STAGES];
   logic [2:0]       w_op    [0:STAGES];
   logic [TAGW-1:0]  w_tag   [0:STAGES];
   logic             w_rdy   [0:STAGES];
   logic             w_zero  [0:STAGES-1];

   assign w_valid[0]     = bus.in_valid;
   assign w_data[0]      = bus.in_a;
   assign w_shamt[0]     = bus.in_shamt;
   assign w_op[0]        = bus.in_op;
   assign w_tag[0]       = bus.in_tag;
   assign w_rdy[STAGES]  = bus.out_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      shift_stage #(
         .WIDTH  (WIDTH),
         .TAGW   (TAGW),
         .STAGES (STAGES),
         .IDX    (s),
         .SHW    (SHW)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .i_valid (w_valid[s]),
         .i_data  (w_data[s]),
         .i_shamt (w_shamt[s]),
         .i_op    (w_op[s]),
         .i_tag   (w_tag[s]),
         .i_take  (w_rdy[s+1]),
         .o_ready (w_rdy[s]),
         .o_valid (w_valid[s+1]),
         .o_data  (w_data[s+1]),
         .o_shamt (w_shamt[s+1]),
         .o_op    (w_op[s+1]),
         .o_tag   (w_tag[s+1]),
         .o_zero  (w_zero[s])
      );
   end

   assign bus.in_ready  = !rst && !flush && w_rdy[0];
   assign bus.out_valid = w_valid[STAGES];
   assign bus.out_o     = w_data[STAGES];
   assign bus.out_tag   = w_tag[STAGES];
   assign bus.out_zero  = w_zero[STAGES-1];
endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - scoreboard bench for shifter_pipe against a bitwise reference model
module tb_shifter_pipe;
   import shifter_pkg::*;

   localparam int W  = 32;
   localparam int ST = 2;
   localparam int TW = 5;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   cyc = 0;

   shifter_pipe_if #(.WIDTH(W), .TAGW(TW)) bus ();

   shifter_pipe #(.WIDTH(W), .STAGES(ST), .TAGW(TW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0]  o;
      logic [TW-1:0] tag;
      logic          zero;
      int            acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_acc = 0;
   int   n_ret = 0;
   bit   chk_lat = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [4:0] sh,
                                              input logic [2:0] op);
      logic [W-1:0] r;
      int s;
      s = int'(sh);
      for (int i = 0; i < W; i++) begin
         case (op)
            3'd0:    r[i] = (i >= s) ? a[i-s] : 1'b0;
            3'd1:    r[i] = (i + s < W) ? a[i+s] : 1'b0;
            3'd2:    r[i] = (i + s < W) ? a[i+s] : a[W-1];
            3'd3:    r[i] = a[(i - s + W) % W];
            3'd4:    r[i] = a[(i + s) % W];
            default: r[i] = a[i];
         endcase
      end
      return r;
   endfunction

   // Monitor: retire, squash, then record newly accepted operations
   logic [W-1:0]  p_o;
   logic [TW-1:0] p_tag;
   logic          p_zero;
   bit            p_stall = 1'b0;

   always @(negedge clk) begin : mon
      exp_t e;
      logic [W-1:0] r;
      if (rst) begin
         sb.delete();
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_o", 64'(bus.out_o), 64'(p_o));
            chk("stall_tag", 64'(bus.out_tag), 64'(p_tag));
            chk("stall_zero", 64'(bus.out_zero), 64'(p_zero));
         end
         p_stall = bus.out_valid && !bus.out_ready && !flush;
         p_o     = bus.out_o;
         p_tag   = bus.out_tag;
         p_zero  = bus.out_zero;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got tag %0d o 0x%0h, expected no output", bus.out_tag, bus.out_o);
            end else begin
               e = sb.pop_front();
               chk("out_o", 64'(bus.out_o), 64'(e.o));
               chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
               chk("out_zero", 64'(bus.out_zero), 64'(e.zero));
               if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(ST));
               n_ret++;
            end
         end
         if (flush) sb.delete();
         if (bus.in_valid && bus.in_ready) begin
            r = ref_shift(bus.in_a, bus.in_shamt, bus.in_op);
            sb.push_back('{o: r, tag: bus.in_tag, zero: (r == '0), acc: cyc});
            n_acc++;
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [4:0] sh, input logic [2:0] op,
                       input logic [TW-1:0] tag);
      int  t;
      bit  ok;
      t  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_shamt = sh;
      bus.in_op    = op;
      bus.in_tag   = tag;
      do begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 200);
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got no in_ready for tag %0d, expected acceptance within 200 cycles", tag);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_acc;
      int base_ret;
      int c0;
      bit done;
      logic [W-1:0] a;

      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_shamt = '0;
      bus.in_op = '0;
      bus.in_tag = '0;
      bus.out_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_rst_out_o", 64'(bus.out_o), 64'd0);
      chk("post_rst_out_tag", 64'(bus.out_tag), 64'd0);
      chk("post_rst_out_zero", 64'(bus.out_zero), 64'd0);
      @(posedge clk); #1;

      // Directed op/boundary cases at full throughput
      chk_lat = 1'b1;
      send(32'h0000_0001, 5'd31, OP_SLL, 5'd3);
      send(32'h8000_0000, 5'd4, OP_SRA, 5'd1);
      send(32'h8000_0000, 5'd4, OP_SRL, 5'd2);
      send(32'h0000_00FF, 5'd8, OP_SRL, 5'd4);
      send(32'h1234_5678, 5'd8, OP_ROR, 5'd5);
      send(32'h1234_5678, 5'd4, OP_ROL, 5'd6);
      for (int op = 0; op < 8; op++) send(32'hA5C3_0F96, 5'd0, 3'(op), 5'(8 + op));
      send(32'h1234_5678, 5'd13, 3'd7, 5'd20);
      send(32'h0000_0000, 5'd9, OP_ROL, 5'd21);
      bus.in_valid = 1'b0;
      drain();

      // Back-pressure: tags 1..6 against a stalled consumer
      chk_lat = 1'b0;
      base_acc = n_acc;
      base_ret = n_ret;
      bus.out_ready = 1'b0;
      fork
         begin
            for (int t = 1; t <= 6; t++) send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 5'(t));
            bus.in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_held", 64'(n_acc - base_acc), 64'd2);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_all_out", 64'(n_ret - base_ret), 64'd6);

      // Flush with two in flight and a concurrent input
      chk_lat = 1'b1;
      base_acc = n_acc;
      base_ret = n_ret;
      send(32'hDEAD_BEEF, 5'd3, OP_ROL, 5'd10);
      send(32'hCAFE_F00D, 5'd7, OP_SRA, 5'd11);
      flush = 1'b1;
      bus.in_a = 32'h0F0F_0F0F;
      bus.in_tag = 5'd12;
      @(negedge clk);
      chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
      chk("flush_accepted", 64'(n_acc - base_acc), 64'd2);
      chk("flush_delivered", 64'(n_ret - base_ret), 64'd1);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_no_late_out", 64'(n_ret - base_ret), 64'd1);

      // Reset with the pipeline full
      chk_lat = 1'b0;
      bus.out_ready = 1'b0;
      send(32'h0000_0F00, 5'd2, OP_SLL, 5'd13);
      send(32'h0000_0F00, 5'd2, OP_SRL, 5'd14);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      base_ret = n_ret;
      @(negedge clk);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_out_o", 64'(bus.out_o), 64'd0);
      chk("midrst_out_tag", 64'(bus.out_tag), 64'd0);
      chk("midrst_out_zero", 64'(bus.out_zero), 64'd0);
      chk("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      chk_lat = 1'b1;
      send(32'h8000_0001, 5'd1, OP_ROR, 5'd15);
      bus.in_valid = 1'b0;
      drain();
      chk("midrst_one_out", 64'(n_ret - base_ret), 64'd1);

      // Random ops with random back-pressure
      chk_lat = 1'b0;
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               a = $urandom;
               if ($urandom_range(0, 9) == 0) a = '0;
               send(a, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
               if ($urandom_range(0, 3) == 0) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk); #1;
               end
            end
            bus.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // Full-rate stream: one accept per cycle and fixed latency
      chk_lat = 1'b1;
      c0 = cyc;
      for (int n = 0; n < 50; n++) send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 5'(n));
      chk("throughput_cycles", 64'(cyc - c0), 64'd50);
      bus.in_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter for the pipelined CPU's EX stage.
- Successor to the fixed 32-bit combinational left shifter: generalised width, more shift modes, configurable pipeline depth.
- Valid/ready handshake on input and output, a pass-through tag for writeback routing, and a flush input for branch/exception squash.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8..64.
- STAGES, 2, pipeline register stages (= latency in cycles); 1..log2(WIDTH).
- TAGW, 5, width of the sideband tag (destination register index).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_a  in  WIDTH  operand to shift.
- in_shamt  in  SHW  shift amount, SHW = log2(WIDTH); only these low bits are used.
- in_op  in  3  operation code (see package).
- in_tag  in  TAGW  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_o  out  WIDTH  result.
- out_tag  out  TAGW  tag of the result.
- out_zero  out  1  high when out_o == 0.

Behaviour:
- Ops:
  - 0 SLL: logical left, zero fill.
  - 1 SRL: logical right, zero fill.
  - 2 SRA: arithmetic right, fill with in_a[WIDTH-1].
  - 3 ROL: rotate left.
  - 4 ROR: rotate right.
  - 5-7 reserved: out_o = in_a unchanged.
- Shift amount 0 returns in_a for every op.
- Shift amounts are modulo WIDTH by construction; no out-of-range case exists.
- Level decomposition:
  - Level k (0..SHW-1) shifts by 2^k when in_shamt[k] is set.
  - Level k is evaluated in stage s = floor(k*STAGES/SHW).
  - Each stage ends in a register holding valid, partial data, remaining shamt bits, op, and tag.
- Latency: an operation accepted at edge N presents out_valid at edge N+STAGES, provided no downstream stall.
- Throughput: one operation per cycle while out_ready = 1.
- Stage advance rule:
  - Stage i loads when its register is empty or stage i+1 (or the consumer, for the last stage) takes its contents in the same cycle.
  - Otherwise it holds its contents.
- in_ready = !flush && (stage0 empty || stage0 advances). This is combinational from out_ready through the chain; no skid buffer.
- Transfer happens only when valid && ready. Results leave strictly in acceptance order; none are dropped or duplicated.
- out_o, out_tag and out_zero are registered. They stay stable while out_valid && !out_ready.
- out_zero is computed in the final stage from the final data.
- Flush:
  - In the cycle flush = 1, all stage valid bits clear at the next edge.
  - in_ready = 0, so any concurrent in_valid is not accepted.
  - A result handshaking in that same cycle (out_valid && out_ready) still counts as delivered.
- Reset (rst = 1 at an edge) has priority over flush and handshakes.
  - All valid bits, out_o, out_tag and out_zero go to 0.
  - in_ready reads 0 while rst = 1 and 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight work with no output.
- Simultaneous input accept and output retire when full: both occur; occupancy is unchanged.

Decomposition:
- Package shifter_pkg holds:
  - op encodings OP_SLL = 0 … OP_ROR = 4;
  - the SHW derivation function (clog2);
  - the stage-assignment function mapping level to stage.
- One sub-module, shift_stage:
  - one pipeline stage, performing its assigned levels combinationally plus the register slot and advance logic;
  - instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, STAGES=2, out_ready=1 unless stated):
1. SLL a=0x0000_0001 shamt=31 tag=3 → out_o=0x8000_0000, tag=3, zero=0, out_valid exactly 2 cycles after accept.
2. SRA a=0x8000_0000 shamt=4 → 0xF800_0000; SRL same operands → 0x0800_0000; SRL a=0x0000_00FF shamt=8 → 0x0000_0000 with zero=1.
3. ROR a=0x1234_5678 shamt=8 → 0x7812_3456; ROL same a shamt=4 → 0x2345_6781; any op shamt=0 → a unchanged; op=7 → a unchanged.
4. Stream tags 1..6 back-to-back with out_ready=0 for cycles 2..5:
   - in_ready falls once 2 operations are held;
   - outputs stay stable while stalled;
   - after release, all 6 appear in tag order, none lost.
5. Two operations in flight, pulse flush with in_valid=1:
   - out_valid=0 next cycle; concurrent input not accepted;
   - in_ready=1 the cycle after.
6. Assert rst for one cycle with the pipeline full:
   - all outputs 0, no result emitted;
   - next operation after reset completes with normal 2-cycle latency.
